operand_buf: RTL and testbench
==============================

OPERAND_BUF -- requirements
Module: operand_buf

Interface
REQ-001 The module SHALL have parameter DATA_W, default `SARRAY_LOAD_WIDTH, meaning the width of one stored row.
REQ-002 The module SHALL have parameter DEPTH, default 64, meaning rows per bank.
REQ-003 The module SHALL have parameter NBANK, default 2, meaning the number of banks (minimum 2).
REQ-004 The module SHALL have derived widths AW = clog2(DEPTH) and BW = max(1, clog2(NBANK)).
REQ-005 The module SHALL have one clock; reset is synchronous and active-high. Ports: clk, input, 1, clock; rst, input, 1, synchronous active-high reset.
REQ-006 The module SHALL have the write ports: wr_valid_i in 1 (write strobe); wr_bank_i in BW; wr_addr_i in AW; wr_data_i in DATA_W; wr_last_i in 1 (commits the bank after this write).
REQ-007 The module SHALL have the read ports: rd_valid_i in 1; rd_bank_i in BW; rd_addr_i in AW.
REQ-008 The module SHALL have the release ports: rel_valid_i in 1 and rel_bank_i in BW, which return a bank to EMPTY.
REQ-009 The module SHALL have the outputs: rd_ret_valid_o out 1; rd_ret_data_o out DATA_W; bank_empty_o out NBANK; bank_full_o out NBANK; err_o out 1 (sticky protocol error).

Function
REQ-010 Each bank SHALL hold a state EMPTY, FILLING or FULL.
REQ-011 A bank SHALL transition EMPTY->FILLING on an accepted write without wr_last_i, EMPTY/FILLING->FULL on an accepted write with wr_last_i, and FULL->EMPTY on rel_valid_i.
REQ-012 A write SHALL be accepted only when the target bank's state is EMPTY or FILLING, wr_bank_i < NBANK and wr_addr_i < DEPTH; otherwise it SHALL be dropped (storage and state unchanged) and err_o SHALL be set.
REQ-013 A read SHALL be accepted only when the bank is FULL and its indices are in range; rd_ret_valid_o SHALL be 1 exactly one cycle after an accepted read, with rd_ret_data_o registered.
REQ-014 A rejected read SHALL give rd_ret_valid_o=0 on the next cycle and set err_o.
REQ-015 rd_ret_data_o SHALL hold its last value when rd_ret_valid_o=0.
REQ-016 A release of a non-FULL or out-of-range bank SHALL be ignored and SHALL set err_o.
REQ-017 All accept checks SHALL use the state at the start of the cycle.
REQ-018 A same-cycle release and write to one FULL bank SHALL drop the write (with err) and leave the bank EMPTY.
REQ-019 A same-cycle wr_last_i and read to one FILLING bank SHALL reject the read and leave the bank FULL.
REQ-020 A same-cycle read and release of one FULL bank SHALL accept the read, return the pre-release data, and leave the bank EMPTY.
REQ-021 Operations on different banks in the same cycle SHALL be fully independent (one write, one read and one release per cycle).
REQ-022 Rows not written during the fill SHALL read back as stale contents, which is not an error.
REQ-023 bank_empty_o[b] SHALL be 1 iff bank b is EMPTY, and bank_full_o[b] SHALL be 1 iff bank b is FULL; both SHALL be registered state with no input combinational path.
REQ-024 err_o SHALL be sticky until rst.

Reset
REQ-025 On rst, all banks SHALL become EMPTY (bank_empty_o all ones, bank_full_o 0), rd_ret_valid_o SHALL be 0, rd_ret_data_o SHALL be 0 and err_o SHALL be 0.
REQ-026 Storage contents SHALL NOT be reset.
REQ-027 A read accepted in the cycle rst asserts SHALL NOT produce rd_ret_valid_o.
REQ-028 rst SHALL take priority over all same-cycle operations.

Structure
REQ-029 The shared package SHALL hold the bank-state enum (EMPTY/FILLING/FULL) and default DATA_W/DEPTH/NBANK constants.
REQ-030 The design SHALL use one sub-module, operand_buf_bank (storage array plus state register for one bank), instantiated NBANK times.
REQ-031 The top level SHALL contain the index decode, read-mux/return register and err logic.

Verification
REQ-032 Fill bank 0 addr 0..63 with data=addr+0x100, last on 63, then read addr 5 -> bank_full_o=01, next-cycle ret_valid=1 with data 0x105.
REQ-033 Ping-pong: bank 1 is filled while bank 0 is read every cycle, then bank 0 is released -> reads return no errors, bank_empty_o=01 and bank_full_o=10.
REQ-034 Write to FULL bank 0 -> data unchanged on readback and err_o=1 stays set.
REQ-035 The same-cycle read and release of bank 1 -> the old data is returned and bank 1 becomes EMPTY; a read of bank 1 on the following cycle -> ret_valid=0 and err=1.
REQ-036 NBANK=3, DEPTH=16: write to bank 3 -> dropped with err; wr_last on addr 0 only -> bank FULL.
REQ-037 Assert rst mid-fill of bank 0 with a read of bank 1 in flight -> no ret_valid next cycle, all banks EMPTY, err_o=0.

Source files
------------

// File: rtl/operand_buf_pkg.sv
// Shared types and default sizing for the operand buffer.
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 32
`endif

package operand_buf_pkg;

    // Life cycle of one bank: filled by the producer, read by the consumer, then released.
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    localparam int OB_DATA_W = `SARRAY_LOAD_WIDTH;
    localparam int OB_DEPTH  = 64;
    localparam int OB_NBANK  = 2;

    // Bank index width; never narrower than one bit.
    function automatic int bank_idx_w(input int nbank);
        return (nbank > 2) ? $clog2(nbank) : 1;
    endfunction

endpackage

// File: rtl/operand_buf_if.sv
// Write / read / release / status signals of the operand buffer.
interface operand_buf_if
    import operand_buf_pkg::*;
#(
    parameter int DATA_W = OB_DATA_W,
    parameter int DEPTH  = OB_DEPTH,
    parameter int NBANK  = OB_NBANK
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = bank_idx_w(NBANK);

    logic              wr_valid_i;
    logic [BW-1:0]     wr_bank_i;
    logic [AW-1:0]     wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_last_i;

    logic              rd_valid_i;
    logic [BW-1:0]     rd_bank_i;
    logic [AW-1:0]     rd_addr_i;

    logic              rel_valid_i;
    logic [BW-1:0]     rel_bank_i;

    logic              rd_ret_valid_o;
    logic [DATA_W-1:0] rd_ret_data_o;
    logic [NBANK-1:0]  bank_empty_o;
    logic [NBANK-1:0]  bank_full_o;
    logic              err_o;

    modport master (
        output wr_valid_i, wr_bank_i, wr_addr_i, wr_data_i, wr_last_i,
        output rd_valid_i, rd_bank_i, rd_addr_i,
        output rel_valid_i, rel_bank_i,
        input  rd_ret_valid_o, rd_ret_data_o, bank_empty_o, bank_full_o, err_o
    );

    modport slave (
        input  wr_valid_i, wr_bank_i, wr_addr_i, wr_data_i, wr_last_i,
        input  rd_valid_i, rd_bank_i, rd_addr_i,
        input  rel_valid_i, rel_bank_i,
        output rd_ret_valid_o, rd_ret_data_o, bank_empty_o, bank_full_o, err_o
    );

endinterface

// File: rtl/operand_buf_bank.sv
// One bank: row storage plus its EMPTY/FILLING/FULL state register.
// wr_en / rel_en arrive already qualified by the top level.
module operand_buf_bank
    import operand_buf_pkg::*;
#(
    parameter int DATA_W = OB_DATA_W,
    parameter int DEPTH  = OB_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_last,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rel_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              is_empty,
    output logic              is_full
);

    logic [DATA_W-1:0] mem [DEPTH];
    bank_state_e       state;

    // Row storage; deliberately not reset, so unwritten rows keep stale contents.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

    // Bank state machine with registered empty/full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BANK_EMPTY;
            is_empty <= 1'b1;
            is_full  <= 1'b0;
        end else begin
            case (state)
                BANK_EMPTY, BANK_FILLING: begin
                    if (wr_en) begin
                        if (wr_last) begin
                            state    <= BANK_FULL;
                            is_empty <= 1'b0;
                            is_full  <= 1'b1;
                        end else begin
                            state    <= BANK_FILLING;
                            is_empty <= 1'b0;
                            is_full  <= 1'b0;
                        end
                    end
                end
                BANK_FULL: begin
                    if (rel_en) begin
                        state    <= BANK_EMPTY;
                        is_empty <= 1'b1;
                        is_full  <= 1'b0;
                    end
                end
                default: begin
                    state    <= BANK_EMPTY;
                    is_empty <= 1'b1;
                    is_full  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/operand_buf.sv
// Multi-bank operand buffer: index decode, accept checks, read return and
// sticky protocol error. All accept checks look at bank state from the start
// of the cycle, so same-cycle write/read/release on one bank resolve cleanly.
module operand_buf
    import operand_buf_pkg::*;
#(
    parameter int DATA_W = `SARRAY_LOAD_WIDTH,
    parameter int DEPTH  = OB_DEPTH,
    parameter int NBANK  = OB_NBANK
) (
    input  logic          clk,
    input  logic          rst,
    operand_buf_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = bank_idx_w(NBANK);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [BW:0] NBANK_L = (BW+1)'(NBANK);

    logic [NBANK-1:0]  empty_vec;
    logic [NBANK-1:0]  full_vec;
    logic [NBANK-1:0]  wr_en_vec;
    logic [NBANK-1:0]  rel_en_vec;
    logic [DATA_W-1:0] bank_rd_data [NBANK];

    logic              wr_in_rng, rd_in_rng, rel_in_rng;
    logic              wr_tgt_full, rd_tgt_full, rel_tgt_full;
    logic              wr_ok, rd_ok, rel_ok;
    logic              any_bad;
    logic [DATA_W-1:0] rd_sel_data;

    logic              ret_valid_q;
    logic [DATA_W-1:0] ret_data_q;
    logic              err_q;

    assign wr_in_rng  = ({1'b0, bus.wr_bank_i}  < NBANK_L) && ({1'b0, bus.wr_addr_i} < DEPTH_L);
    assign rd_in_rng  = ({1'b0, bus.rd_bank_i}  < NBANK_L) && ({1'b0, bus.rd_addr_i} < DEPTH_L);
    assign rel_in_rng = ({1'b0, bus.rel_bank_i} < NBANK_L);

    // Look up the current state of each addressed bank and the read-mux data.
    always_comb begin
        wr_tgt_full  = 1'b0;
        rd_tgt_full  = 1'b0;
        rel_tgt_full = 1'b0;
        rd_sel_data  = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (bus.wr_bank_i == BW'(b)) begin
                wr_tgt_full = full_vec[b];
            end
            if (bus.rd_bank_i == BW'(b)) begin
                rd_tgt_full = full_vec[b];
                rd_sel_data = bank_rd_data[b];
            end
            if (bus.rel_bank_i == BW'(b)) begin
                rel_tgt_full = full_vec[b];
            end
        end
    end

    // A write may only land in an EMPTY or FILLING bank; reads and releases need FULL.
    assign wr_ok  = bus.wr_valid_i  && wr_in_rng  && !wr_tgt_full;
    assign rd_ok  = bus.rd_valid_i  && rd_in_rng  && rd_tgt_full;
    assign rel_ok = bus.rel_valid_i && rel_in_rng && rel_tgt_full;

    assign any_bad = (bus.wr_valid_i  && !wr_ok)
                   || (bus.rd_valid_i  && !rd_ok)
                   || (bus.rel_valid_i && !rel_ok);

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        assign wr_en_vec[b]  = wr_ok  && (bus.wr_bank_i  == BW'(b));
        assign rel_en_vec[b] = rel_ok && (bus.rel_bank_i == BW'(b));

        operand_buf_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en_vec[b]),
            .wr_last  (bus.wr_last_i),
            .wr_addr  (bus.wr_addr_i),
            .wr_data  (bus.wr_data_i),
            .rel_en   (rel_en_vec[b]),
            .rd_addr  (bus.rd_addr_i),
            .rd_data  (bank_rd_data[b]),
            .is_empty (empty_vec[b]),
            .is_full  (full_vec[b])
        );
    end

    // Read return register; data holds its last value between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_valid_q <= 1'b0;
            ret_data_q  <= '0;
        end else begin
            ret_valid_q <= rd_ok;
            if (rd_ok) begin
                ret_data_q <= rd_sel_data;
            end
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (any_bad) begin
            err_q <= 1'b1;
        end
    end

    assign bus.rd_ret_valid_o = ret_valid_q;
    assign bus.rd_ret_data_o  = ret_data_q;
    assign bus.bank_empty_o   = empty_vec;
    assign bus.bank_full_o    = full_vec;
    assign bus.err_o          = err_q;

endmodule

// File: tb/tb_operand_buf.sv
// Bench for operand_buf: a 2-bank/64-row instance checked against a reference
// model every cycle, plus a 3-bank/16-row instance driven from a vector table.
module tb_operand_buf;
    import operand_buf_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    operand_buf_if #(.DATA_W(DW), .DEPTH(64), .NBANK(2)) bus_a ();
    operand_buf_if #(.DATA_W(DW), .DEPTH(16), .NBANK(3)) bus_b ();

    operand_buf #(.DATA_W(DW), .DEPTH(64), .NBANK(2)) dut_a (
        .clk (clk), .rst (rst_a), .bus (bus_a)
    );
    operand_buf #(.DATA_W(DW), .DEPTH(16), .NBANK(3)) dut_b (
        .clk (clk), .rst (rst_b), .bus (bus_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model of instance A: bank state 0=empty 1=filling 2=full.
    int          m_state [2];
    logic [31:0] m_mem   [2][64];
    bit          m_known [2][64];
    bit          m_err;
    bit          m_rv;
    logic [31:0] m_rd;
    bit          m_rd_known;

    typedef struct {
        bit          rst;
        bit          wv;  logic [1:0] wb; logic [3:0] wa; logic [31:0] wd; bit wl;
        bit          rv;  logic [1:0] rb; logic [3:0] ra;
        bit          lv;  logic [1:0] lb;
        bit          e_rv; logic [31:0] e_rd; logic [2:0] e_emp; logic [2:0] e_full; bit e_err;
    } vec_t;

    vec_t tab [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_a();
        bus_a.wr_valid_i  = 1'b0; bus_a.wr_bank_i = 1'b0; bus_a.wr_addr_i = 6'd0;
        bus_a.wr_data_i   = 32'd0; bus_a.wr_last_i = 1'b0;
        bus_a.rd_valid_i  = 1'b0; bus_a.rd_bank_i = 1'b0; bus_a.rd_addr_i = 6'd0;
        bus_a.rel_valid_i = 1'b0; bus_a.rel_bank_i = 1'b0;
    endtask

    task automatic wr_a(input int b, input int a, input logic [31:0] d, input bit last);
        bus_a.wr_valid_i = 1'b1; bus_a.wr_bank_i = 1'(b); bus_a.wr_addr_i = 6'(a);
        bus_a.wr_data_i  = d;    bus_a.wr_last_i = last;
    endtask

    task automatic rd_a(input int b, input int a);
        bus_a.rd_valid_i = 1'b1; bus_a.rd_bank_i = 1'(b); bus_a.rd_addr_i = 6'(a);
    endtask

    task automatic rel_a(input int b);
        bus_a.rel_valid_i = 1'b1; bus_a.rel_bank_i = 1'(b);
    endtask

    // Advance one clock, update the model from the inputs seen at the edge, compare A.
    task automatic step(input string tag);
        bit          s_rst = rst_a;
        bit          s_wv  = bus_a.wr_valid_i;
        int          s_wb  = int'(bus_a.wr_bank_i);
        int          s_wa  = int'(bus_a.wr_addr_i);
        logic [31:0] s_wd  = bus_a.wr_data_i;
        bit          s_wl  = bus_a.wr_last_i;
        bit          s_rv  = bus_a.rd_valid_i;
        int          s_rb  = int'(bus_a.rd_bank_i);
        int          s_ra  = int'(bus_a.rd_addr_i);
        bit          s_lv  = bus_a.rel_valid_i;
        int          s_lb  = int'(bus_a.rel_bank_i);
        int          old [2];
        bit          wok, rok, lok;
        logic [1:0]  e_emp, e_full;

        @(posedge clk);
        #1;
        if (s_rst) begin
            m_state[0] = 0; m_state[1] = 0;
            m_err = 1'b0; m_rv = 1'b0; m_rd = 32'd0; m_rd_known = 1'b1;
        end else begin
            old = m_state;
            wok = s_wv && (old[s_wb] != 2);
            rok = s_rv && (old[s_rb] == 2);
            lok = s_lv && (old[s_lb] == 2);
            m_rv = rok;
            if (rok) begin
                m_rd       = m_mem[s_rb][s_ra];
                m_rd_known = m_known[s_rb][s_ra];
            end
            if (wok) begin
                m_mem[s_wb][s_wa]   = s_wd;
                m_known[s_wb][s_wa] = 1'b1;
                m_state[s_wb]       = s_wl ? 2 : 1;
            end
            if (lok) m_state[s_lb] = 0;
            if ((s_wv && !wok) || (s_rv && !rok) || (s_lv && !lok)) m_err = 1'b1;
        end
        for (int b = 0; b < 2; b++) begin
            e_emp[b]  = (m_state[b] == 0);
            e_full[b] = (m_state[b] == 2);
        end
        check({tag, ".empty"},     32'(bus_a.bank_empty_o),   32'(e_emp));
        check({tag, ".full"},      32'(bus_a.bank_full_o),    32'(e_full));
        check({tag, ".err"},       32'(bus_a.err_o),          32'(m_err));
        check({tag, ".ret_valid"}, 32'(bus_a.rd_ret_valid_o), 32'(m_rv));
        if (m_rd_known) check({tag, ".ret_data"}, bus_a.rd_ret_data_o, m_rd);
    endtask

    task automatic fill_a(input int b, input logic [31:0] base);
        for (int a = 0; a < 64; a++) begin
            idle_a();
            wr_a(b, a, base + 32'(a), a == 63);
            step("fill");
        end
        idle_a();
    endtask

    function automatic vec_t mkv(
        input bit rst, input bit wv, input logic [1:0] wb, input logic [3:0] wa,
        input logic [31:0] wd, input bit wl, input bit rv, input logic [1:0] rb,
        input logic [3:0] ra, input bit lv, input logic [1:0] lb, input bit e_rv,
        input logic [31:0] e_rd, input logic [2:0] e_emp, input logic [2:0] e_full, input bit e_err);
        vec_t v;
        v.rst = rst; v.wv = wv; v.wb = wb; v.wa = wa; v.wd = wd; v.wl = wl;
        v.rv = rv; v.rb = rb; v.ra = ra; v.lv = lv; v.lb = lb;
        v.e_rv = e_rv; v.e_rd = e_rd; v.e_emp = e_emp; v.e_full = e_full; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 64; a++) m_known[b][a] = 1'b0;
        m_rd_known = 1'b0;
        m_state[0] = 0; m_state[1] = 0;
        m_err = 1'b0; m_rv = 1'b0; m_rd = 32'd0;

        rst_a = 1'b1;
        rst_b = 1'b1;
        idle_a();
        bus_b.wr_valid_i = 1'b0; bus_b.wr_bank_i = 2'd0; bus_b.wr_addr_i = 4'd0;
        bus_b.wr_data_i = 32'd0; bus_b.wr_last_i = 1'b0;
        bus_b.rd_valid_i = 1'b0; bus_b.rd_bank_i = 2'd0; bus_b.rd_addr_i = 4'd0;
        bus_b.rel_valid_i = 1'b0; bus_b.rel_bank_i = 2'd0;

        step("reset");
        check("reset.empty_all", 32'(bus_a.bank_empty_o), 32'h3);
        check("reset.data_zero", bus_a.rd_ret_data_o, 32'h0);
        rst_a = 1'b0;

        // Fill bank 0 with addr+0x100, then read row 5.
        fill_a(0, 32'h100);
        check("fill0.full", 32'(bus_a.bank_full_o), 32'h1);
        rd_a(0, 5);
        step("rd5");
        check("rd5.valid", 32'(bus_a.rd_ret_valid_o), 32'h1);
        check("rd5.data",  bus_a.rd_ret_data_o, 32'h105);
        idle_a();

        // Ping-pong: fill bank 1 while reading bank 0 every cycle.
        for (int i = 0; i < 64; i++) begin
            idle_a();
            wr_a(1, i, 32'h2000 + 32'(i * 3), i == 63);
            rd_a(0, i);
            step("pingpong");
            check("pingpong.valid", 32'(bus_a.rd_ret_valid_o), 32'h1);
            check("pingpong.data",  bus_a.rd_ret_data_o, 32'h100 + 32'(i));
        end
        idle_a();
        rel_a(0);
        step("rel0");
        check("rel0.empty", 32'(bus_a.bank_empty_o), 32'h1);
        check("rel0.full",  32'(bus_a.bank_full_o),  32'h2);
        check("rel0.err",   32'(bus_a.err_o),        32'h0);

        // Same-cycle read and release of bank 1, then a read of the now-empty bank.
        idle_a();
        rd_a(1, 7);
        rel_a(1);
        step("rdrel1");
        check("rdrel1.data",  bus_a.rd_ret_data_o, 32'h2015);
        check("rdrel1.empty", 32'(bus_a.bank_empty_o), 32'h3);
        idle_a();
        rd_a(1, 7);
        step("rd_empty1");
        check("rd_empty1.valid", 32'(bus_a.rd_ret_valid_o), 32'h0);
        check("rd_empty1.err",   32'(bus_a.err_o), 32'h1);
        idle_a();

        // Write into a FULL bank is dropped and the error sticks.
        rst_a = 1'b1;
        step("rst2");
        rst_a = 1'b0;
        fill_a(0, 32'h300);
        wr_a(0, 5, 32'hDEAD, 1'b0);
        step("wr_full");
        check("wr_full.err", 32'(bus_a.err_o), 32'h1);
        idle_a();
        rd_a(0, 5);
        step("wr_full_rd");
        check("wr_full_rd.data", bus_a.rd_ret_data_o, 32'h305);
        idle_a();
        for (int i = 0; i < 4; i++) step("err_sticky");
        check("err_sticky", 32'(bus_a.err_o), 32'h1);

        // Reset mid-fill of bank 0 with a read of bank 1 issued in the reset cycle.
        rst_a = 1'b1;
        step("rst3");
        rst_a = 1'b0;
        fill_a(1, 32'h5A5A0000);
        for (int a = 0; a < 10; a++) begin
            idle_a();
            wr_a(0, a, 32'h700 + 32'(a), 1'b0);
            step("midfill");
        end
        idle_a();
        wr_a(0, 10, 32'h70A, 1'b0);
        rd_a(1, 3);
        rst_a = 1'b1;
        step("rst_mid");
        check("rst_mid.valid", 32'(bus_a.rd_ret_valid_o), 32'h0);
        check("rst_mid.empty", 32'(bus_a.bank_empty_o), 32'h3);
        check("rst_mid.err",   32'(bus_a.err_o), 32'h0);
        rst_a = 1'b0;
        idle_a();

        // Randomized traffic on instance A against the model.
        for (int i = 0; i < 3000; i++) begin
            idle_a();
            rst_a = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 1) == 1)
                wr_a($urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1)
                rd_a($urandom_range(0, 1), $urandom_range(0, 15));
            if ($urandom_range(0, 11) == 0)
                rel_a($urandom_range(0, 1));
            step("rand");
        end
        rst_a = 1'b0;
        idle_a();

        // Vector table for the 3-bank, 16-row instance.
        tab[0]  = mkv(1'b1, 1'b0, 2'd0, 4'd0,  32'h00, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 1'b0, 32'h00, 3'b111, 3'b000, 1'b0);
        tab[1]  = mkv(1'b0, 1'b1, 2'd3, 4'd0,  32'hAA, 1'b1, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 1'b0, 32'h00, 3'b111, 3'b000, 1'b1);
        tab[2]  = mkv(1'b0, 1'b1, 2'd0, 4'd0,  32'h55, 1'b1, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 1'b0, 32'h00, 3'b110, 3'b001, 1'b1);
        tab[3]  = mkv(1'b0, 1'b0, 2'd0, 4'd0,  32'h00, 1'b0, 1'b1, 2'd0, 4'd0,  1'b0, 2'd0, 1'b1, 32'h55, 3'b110, 3'b001, 1'b1);
        tab[4]  = mkv(1'b0, 1'b0, 2'd0, 4'd0,  32'h00, 1'b0, 1'b1, 2'd3, 4'd0,  1'b0, 2'd0, 1'b0, 32'h55, 3'b110, 3'b001, 1'b1);
        tab[5]  = mkv(1'b1, 1'b1, 2'd1, 4'd1,  32'h99, 1'b1, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 1'b0, 32'h00, 3'b111, 3'b000, 1'b0);
        tab[6]  = mkv(1'b0, 1'b1, 2'd2, 4'd15, 32'h77, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 1'b0, 32'h00, 3'b011, 3'b000, 1'b0);
        tab[7]  = mkv(1'b0, 1'b1, 2'd2, 4'd3,  32'h33, 1'b1, 1'b1, 2'd2, 4'd15, 1'b0, 2'd0, 1'b0, 32'h00, 3'b011, 3'b100, 1'b1);
        tab[8]  = mkv(1'b0, 1'b0, 2'd0, 4'd0,  32'h00, 1'b0, 1'b1, 2'd2, 4'd15, 1'b0, 2'd0, 1'b1, 32'h77, 3'b011, 3'b100, 1'b1);
        tab[9]  = mkv(1'b0, 1'b0, 2'd0, 4'd0,  32'h00, 1'b0, 1'b1, 2'd2, 4'd3,  1'b1, 2'd2, 1'b1, 32'h33, 3'b111, 3'b000, 1'b1);
        tab[10] = mkv(1'b0, 1'b0, 2'd0, 4'd0,  32'h00, 1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd3, 1'b0, 32'h33, 3'b111, 3'b000, 1'b1);
        tab[11] = mkv(1'b1, 1'b0, 2'd0, 4'd0,  32'h00, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 1'b0, 32'h00, 3'b111, 3'b000, 1'b0);
        tab[12] = mkv(1'b0, 1'b1, 2'd1, 4'd0,  32'h11, 1'b1, 1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 1'b0, 32'h00, 3'b101, 3'b010, 1'b0);
        tab[13] = mkv(1'b0, 1'b0, 2'd0, 4'd0,  32'h00, 1'b0, 1'b1, 2'd1, 4'd0,  1'b0, 2'd0, 1'b1, 32'h11, 3'b101, 3'b010, 1'b0);
        tab[14] = mkv(1'b0, 1'b0, 2'd0, 4'd0,  32'h00, 1'b0, 1'b0, 2'd0, 4'd0,  1'b1, 2'd0, 1'b0, 32'h11, 3'b101, 3'b010, 1'b1);

        for (int i = 0; i < 15; i++) begin
            rst_b             = tab[i].rst;
            bus_b.wr_valid_i  = tab[i].wv;
            bus_b.wr_bank_i   = tab[i].wb;
            bus_b.wr_addr_i   = tab[i].wa;
            bus_b.wr_data_i   = tab[i].wd;
            bus_b.wr_last_i   = tab[i].wl;
            bus_b.rd_valid_i  = tab[i].rv;
            bus_b.rd_bank_i   = tab[i].rb;
            bus_b.rd_addr_i   = tab[i].ra;
            bus_b.rel_valid_i = tab[i].lv;
            bus_b.rel_bank_i  = tab[i].lb;
            step("idle_a");
            check($sformatf("b_vec%0d.ret_valid", i), 32'(bus_b.rd_ret_valid_o), 32'(tab[i].e_rv));
            check($sformatf("b_vec%0d.ret_data", i),  bus_b.rd_ret_data_o,       tab[i].e_rd);
            check($sformatf("b_vec%0d.empty", i),     32'(bus_b.bank_empty_o),   32'(tab[i].e_emp));
            check($sformatf("b_vec%0d.full", i),      32'(bus_b.bank_full_o),    32'(tab[i].e_full));
            check($sformatf("b_vec%0d.err", i),       32'(bus_b.err_o),          32'(tab[i].e_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
